// File: rtl/mips_uart.sv
// 8N1 UART for the MIPS device controller: independent TX and RX state machines,
// each bit BAUD_DIV clocks, with a down-counting bit timer that expires at zero.
module mips_uart #(
  parameter int BAUD_DIV = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ser_rxd,
  output logic       ser_txd,
  input  logic [7:0] din,
  input  logic       txd_ld,
  output logic       txd_busy,
  input  logic       rxd_ft,
  output logic       rxd_rdy,
  output logic [7:0] dout
);

  localparam int CW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  // state      | meaning
  // TX_IDLE    | line high, waiting for txd_ld
  // TX_START   | driving start bit (0)
  // TX_DATA    | driving data bits 0..7
  // TX_STOP    | driving stop bit (1)
  // RX_IDLE    | waiting for synced line low
  // RX_START   | waiting half a bit to confirm the start bit
  // RX_DATA    | sampling 8 data bits mid-bit
  // RX_STOP    | sampling stop bit
  // RX_WAIT_HIGH | framing error seen, waiting for line to go high
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_e;

  tx_state_e         tx_state_q, tx_state_d;
  logic [CW-1:0]     tx_cnt_q, tx_cnt_d;
  logic [2:0]        tx_bit_q, tx_bit_d;
  logic [7:0]        tx_shift_q, tx_shift_d;
  logic              txd_q, txd_d;

  rx_state_e         rx_state_q, rx_state_d;
  logic [CW-1:0]     rx_cnt_q, rx_cnt_d;
  logic [2:0]        rx_bit_q, rx_bit_d;
  logic [7:0]        rx_shift_q, rx_shift_d;
  logic [7:0]        dout_q, dout_d;
  logic              rdy_q, rdy_d;
  logic [1:0]        sync_q;
  logic              rx_s;

  assign ser_txd  = txd_q;
  assign txd_busy = (tx_state_q != TX_IDLE);
  assign rxd_rdy  = rdy_q;
  assign dout     = dout_q;
  assign rx_s     = sync_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      txd_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      txd_q      <= txd_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    txd_d      = txd_q;
    case (tx_state_q)
      TX_IDLE: begin
        txd_d = 1'b1;
        if (txd_ld) begin
          tx_shift_d = din;
          tx_cnt_d   = BIT_LAST;
          tx_state_d = TX_START;
          txd_d      = 1'b0;
        end
      end
      TX_START: begin
        if (tx_cnt_q == '0) begin
          tx_cnt_d   = BIT_LAST;
          tx_bit_d   = 3'd0;
          tx_state_d = TX_DATA;
          txd_d      = tx_shift_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q - CNT_ONE;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == '0) begin
          tx_cnt_d = BIT_LAST;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = TX_STOP;
            txd_d      = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            txd_d      = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q - CNT_ONE;
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == '0) begin
          tx_state_d = TX_IDLE;
          txd_d      = 1'b1;
        end else begin
          tx_cnt_d = tx_cnt_q - CNT_ONE;
        end
      end
      default: begin
        tx_state_d = TX_IDLE;
        txd_d      = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q     <= 2'b11;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      dout_q     <= 8'h00;
      rdy_q      <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], ser_rxd};
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      dout_q     <= dout_d;
      rdy_q      <= rdy_d;
    end
  end

  // A valid stop bit sets rxd_rdy even when rxd_ft clears it in the same cycle.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    dout_d     = dout_q;
    rdy_d      = rxd_ft ? 1'b0 : rdy_q;
    case (rx_state_q)
      RX_IDLE: begin
        if (!rx_s) begin
          rx_cnt_d   = HALF_LAST;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt_q == '0) begin
          if (!rx_s) begin
            rx_cnt_d   = BIT_LAST;
            rx_bit_d   = 3'd0;
            rx_state_d = RX_DATA;
          end else begin
            rx_state_d = RX_IDLE;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - CNT_ONE;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == '0) begin
          rx_cnt_d   = BIT_LAST;
          rx_shift_d = {rx_s, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) begin
            rx_state_d = RX_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - CNT_ONE;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == '0) begin
          if (rx_s) begin
            dout_d     = rx_shift_q;
            rdy_d      = 1'b1;
            rx_state_d = RX_IDLE;
          end else begin
            rx_state_d = RX_WAIT_HIGH;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - CNT_ONE;
        end
      end
      RX_WAIT_HIGH: begin
        if (rx_s) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mips_uart.sv
// Directed bench for mips_uart: BAUD_DIV=8 instance for frame-level checks and a
// BAUD_DIV=434 instance in TX-to-RX loopback.
module tb_mips_uart;

  logic       clk;
  logic       rst;
  logic       rxd, txd, txd_ld, busy, rxd_ft, rdy;
  logic [7:0] din, dout;

  logic       lb_line, lb_ld, lb_busy, lb_ft, lb_rdy;
  logic [7:0] lb_din, lb_dout;

  int n_tests = 0;
  int n_fail  = 0;

  mips_uart #(.BAUD_DIV(8)) dut (
    .clk(clk), .rst(rst), .ser_rxd(rxd), .ser_txd(txd), .din(din),
    .txd_ld(txd_ld), .txd_busy(busy), .rxd_ft(rxd_ft), .rxd_rdy(rdy), .dout(dout)
  );

  mips_uart #(.BAUD_DIV(434)) dut_lb (
    .clk(clk), .rst(rst), .ser_rxd(lb_line), .ser_txd(lb_line), .din(lb_din),
    .txd_ld(lb_ld), .txd_busy(lb_busy), .rxd_ft(lb_ft), .rxd_rdy(lb_rdy), .dout(lb_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sends one byte on the BAUD_DIV=8 instance; optionally fires a colliding txd_ld.
  task automatic tx_frame(input logic [7:0] b, input bit inject, input string tag);
    logic [9:0] fr;
    int ok[10];
    int k;
    fr = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) ok[i] = 0;
    din = b; txd_ld = 1'b1;
    @(negedge clk);
    txd_ld = 1'b0; din = 8'h00;
    k = 0;
    while (busy && k < 200) begin
      if (k < 80 && txd === fr[k/8]) ok[k/8]++;
      if (inject && k == 20) begin din = 8'hFF; txd_ld = 1'b1; end
      else txd_ld = 1'b0;
      @(negedge clk);
      k++;
    end
    txd_ld = 1'b0;
    chk({tag, "_busy_len"}, k, 80);
    for (int i = 0; i < 10; i++) chk($sformatf("%s_bit%0d", tag, i), ok[i], 8);
    chk({tag, "_idle_txd"}, txd, 1);
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop, input bit ft_at_stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int c = 0; c < 10; c++) begin
      for (int j = 0; j < 8; j++) begin
        rxd = fr[c];
        if (ft_at_stop && c == 9) rxd_ft = (j == 6);
        @(negedge clk);
      end
    end
    rxd_ft = 1'b0;
  endtask

  task automatic pulse_ft;
    rxd_ft = 1'b1;
    @(negedge clk);
    rxd_ft = 1'b0;
  endtask

  initial begin
    logic [7:0] lb_bytes [3];
    int k;
    lb_bytes[0] = 8'h00; lb_bytes[1] = 8'hFF; lb_bytes[2] = 8'h5A;
    rst = 1'b1; rxd = 1'b1; din = 8'h00; txd_ld = 1'b0; rxd_ft = 1'b0;
    lb_din = 8'h00; lb_ld = 1'b0; lb_ft = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_txd", txd, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rdy", rdy, 0);
    chk("rst_dout", dout, 8'h00);
    rst = 1'b0;
    @(negedge clk);

    tx_frame(8'hA5, 1'b0, "tx_a5");
    tx_frame(8'h96, 1'b1, "tx_collide");

    rx_frame(8'h3C, 1'b1, 1'b0);
    rxd = 1'b1;
    chk("rx_3c_rdy", rdy, 1);
    chk("rx_3c_dout", dout, 8'h3C);
    pulse_ft();
    chk("rx_ft_rdy", rdy, 0);
    chk("rx_ft_dout", dout, 8'h3C);

    rxd = 1'b0;
    repeat (2) @(negedge clk);
    rxd = 1'b1;
    repeat (20) @(negedge clk);
    chk("glitch_rdy", rdy, 0);
    chk("glitch_dout", dout, 8'h3C);

    rx_frame(8'h55, 1'b0, 1'b0);
    repeat (30) @(negedge clk);
    rxd = 1'b1;
    repeat (100) @(negedge clk);
    chk("frame_err_rdy", rdy, 0);
    chk("frame_err_dout", dout, 8'h3C);

    rx_frame(8'h01, 1'b1, 1'b0);
    rxd = 1'b1;
    repeat (4) @(negedge clk);
    rx_frame(8'h02, 1'b1, 1'b0);
    rxd = 1'b1;
    chk("overrun_rdy", rdy, 1);
    chk("overrun_dout", dout, 8'h02);

    repeat (4) @(negedge clk);
    rx_frame(8'h12, 1'b1, 1'b1);
    rxd = 1'b1;
    chk("ft_vs_stop_rdy", rdy, 1);
    chk("ft_vs_stop_dout", dout, 8'h12);
    pulse_ft();

    din = 8'h5A; txd_ld = 1'b1; rxd = 1'b0;
    @(negedge clk);
    txd_ld = 1'b0;
    repeat (40) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_txd", txd, 1);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_rdy", rdy, 0);
    chk("async_rst_dout", dout, 8'h00);
    rxd = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tx_frame(8'hC3, 1'b0, "tx_after_rst");
    chk("after_rst_rdy", rdy, 0);
    chk("after_rst_dout", dout, 8'h00);

    lb_din = lb_bytes[0]; lb_ld = 1'b1;
    @(negedge clk);
    lb_ld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      k = 0;
      while (!lb_rdy && k < 6000) begin @(negedge clk); k++; end
      chk($sformatf("lb_rdy%0d", i), lb_rdy, 1);
      chk($sformatf("lb_byte%0d", i), lb_dout, lb_bytes[i]);
      lb_ft = 1'b1;
      @(negedge clk);
      lb_ft = 1'b0;
      k = 0;
      while (lb_busy && k < 6000) begin @(negedge clk); k++; end
      chk($sformatf("lb_idle%0d", i), lb_busy, 0);
      if (i < 2) begin
        lb_din = lb_bytes[i+1]; lb_ld = 1'b1;
        @(negedge clk);
        lb_ld = 1'b0;
      end
    end
    chk("lb_final_rdy", lb_rdy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
